// File: rtl/dcdc_clk_monitor.sv
// Measures the period and high time of the asynchronous converter clock in clk cycles.
// Flags out-of-range or stopped clocks and captures the converter clock phase at frame sync.
module dcdc_clk_monitor #(
    parameter int CW          = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame,
    input  logic          cnvclk,
    input  logic          cnvext,
    input  logic [CW-1:0] min_per,
    input  logic [CW-1:0] max_per,
    input  logic          clr,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          valid,
    output logic          too_fast,
    output logic          too_slow,
    output logic          lost,
    output logic [CW-1:0] frame_phase,
    output logic          frame_upd
);

    // state | meaning
    // IDLE  | converter clock not expected, counter held at 0
    // ARM   | waiting for the first rising edge
    // MEAS1 | first period in progress, no range checks yet
    // RUN   | continuous measurement with range checks
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_MEAS1 = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   clk_sync_d;
    logic                   clk_lvl;
    logic                   ext_on;
    logic                   rise;
    logic                   fall;

    logic [CW-1:0]          cnt;
    logic [CW:0]            timeout_lim;
    logic                   in_meas;
    logic                   timeout;

    logic                   cnt_clr;
    logic                   lat_high;
    logic                   lat_per;
    logic                   set_valid;
    logic                   clr_valid;
    logic                   chk_range;
    logic                   cap_frame;
    logic                   fast_hit;
    logic                   slow_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync   <= '0;
            ext_sync   <= '0;
            clk_sync_d <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], cnvclk};
            ext_sync   <= {ext_sync[SYNC_STAGES-2:0], cnvext};
            clk_sync_d <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_lvl = clk_sync[SYNC_STAGES-1];
    assign ext_on  = ext_sync[SYNC_STAGES-1];
    assign rise    = clk_lvl & ~clk_sync_d;
    assign fall    = ~clk_lvl & clk_sync_d;

    // Widened compare so max_per = all-ones cannot wrap the limit to zero.
    assign timeout_lim = {1'b0, max_per} + (CW+1)'(1);
    assign in_meas     = ext_on && ((state == S_MEAS1) || (state == S_RUN));
    assign timeout     = in_meas && !rise && ({1'b0, cnt} >= timeout_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!ext_on) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nx = S_ARM;
                S_ARM:   if (rise) state_nx = S_MEAS1;
                S_MEAS1: begin
                    if (timeout) begin
                        state_nx = S_ARM;
                    end else if (rise) begin
                        state_nx = S_RUN;
                    end
                end
                S_RUN:   if (timeout) state_nx = S_ARM;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clr   = !ext_on || (state == S_IDLE);
        lat_high  = in_meas && fall;
        lat_per   = in_meas && rise;
        set_valid = in_meas && rise && (state == S_MEAS1);
        clr_valid = !ext_on || timeout;
        chk_range = in_meas && rise && (state == S_RUN);
        cap_frame = in_meas && frame;
        fast_hit  = chk_range && (cnt < min_per);
        slow_hit  = chk_range && (cnt > max_per);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CW'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            if (lat_per) begin
                period <= cnt;
            end
            if (lat_high) begin
                high_time <= cnt;
            end
            if (clr_valid) begin
                valid <= 1'b0;
            end else if (set_valid) begin
                valid <= 1'b1;
            end
        end
    end

    // Sticky flags: a set in the same cycle as clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            too_fast <= 1'b0;
            too_slow <= 1'b0;
            lost     <= 1'b0;
        end else begin
            too_fast <= (too_fast & ~clr) | fast_hit;
            too_slow <= (too_slow & ~clr) | slow_hit;
            lost     <= (lost & ~clr) | timeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_phase <= '0;
            frame_upd   <= 1'b0;
        end else begin
            frame_upd <= cap_frame;
            if (cap_frame) begin
                frame_phase <= rise ? '0 : cnt;
            end
        end
    end

endmodule

// File: tb/tb_dcdc_clk_monitor.sv
// Directed bench for dcdc_clk_monitor: table of steady converter-clock waveforms
// plus hand sequences for timeout, frame capture, cnvext drop and async reset.
module tb_dcdc_clk_monitor;

    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic          frame;
    logic          cnvclk;
    logic          cnvext;
    logic [CW-1:0] min_per;
    logic [CW-1:0] max_per;
    logic          clr;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          too_fast;
    logic          too_slow;
    logic          lost;
    logic [CW-1:0] frame_phase;
    logic          frame_upd;

    int checks   = 0;
    int failures = 0;

    int gen_en = 0;
    int gen_hi = 16;
    int gen_lo = 16;
    int gen_cnt = 0;

    dcdc_clk_monitor #(.CW(CW), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .cnvclk      (cnvclk),
        .cnvext      (cnvext),
        .min_per     (min_per),
        .max_per     (max_per),
        .clr         (clr),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .too_fast    (too_fast),
        .too_slow    (too_slow),
        .lost        (lost),
        .frame_phase (frame_phase),
        .frame_upd   (frame_upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Converter clock source: changes on negedge, gen_hi cycles high, gen_lo cycles low.
    initial begin
        cnvclk = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_en == 0) begin
                cnvclk  = 1'b0;
                gen_cnt = 0;
            end else begin
                gen_cnt++;
                if (cnvclk && gen_cnt >= gen_hi) begin
                    cnvclk  = 1'b0;
                    gen_cnt = 0;
                end else if (!cnvclk && gen_cnt >= gen_lo) begin
                    cnvclk  = 1'b1;
                    gen_cnt = 0;
                end
            end
        end
    end

    typedef struct {
        int hi;
        int lo;
        int mn;
        int mx;
        int exp_per;
        int exp_ht;
        bit exp_fast;
        bit exp_slow;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_clr();
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int n = 0;
        while (valid !== 1'b1 && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, valid, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_period"}, period, 0);
        chk({nm, "_high"}, high_time, 0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_fast"}, too_fast, 0);
        chk({nm, "_slow"}, too_slow, 0);
        chk({nm, "_lost"}, lost, 0);
        chk({nm, "_phase"}, frame_phase, 0);
        chk({nm, "_upd"}, frame_upd, 0);
    endtask

    initial begin
        // hi, lo, min, max, period, high_time, too_fast, too_slow
        vecs[0] = '{16, 16, 24, 40, 32, 16, 1'b0, 1'b0};
        vecs[1] = '{16, 16, 40, 48, 32, 16, 1'b1, 1'b0};
        vecs[2] = '{12, 12, 24, 40, 24, 12, 1'b0, 1'b0};
        vecs[3] = '{20, 20, 24, 40, 40, 20, 1'b0, 1'b0};
        vecs[4] = '{20, 21, 24, 40, 41, 20, 1'b0, 1'b1};
        vecs[5] = '{ 5, 27, 24, 40, 32,  5, 1'b0, 1'b0};
        vecs[6] = '{10, 13, 24, 40, 23, 10, 1'b1, 1'b0};
        vecs[7] = '{ 8,  8, 10, 15, 16,  8, 1'b0, 1'b1};

        rst     = 1'b1;
        frame   = 1'b0;
        cnvext  = 1'b0;
        clr     = 1'b0;
        min_per = CW'(24);
        max_per = CW'(40);

        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // First measurement: valid after the second rise.
        cnvext = 1'b1;
        gen_hi = 16;
        gen_lo = 16;
        gen_en = 1;
        wait_valid(200, "first_valid");
        chk("first_period", period, 32);
        chk("first_high", high_time, 16);
        chk("first_fast", too_fast, 0);
        chk("first_slow", too_slow, 0);
        chk("first_lost", lost, 0);

        // Steady waveforms; wait out transients, clear, then re-measure.
        for (int i = 0; i < 8; i++) begin
            gen_hi  = vecs[i].hi;
            gen_lo  = vecs[i].lo;
            min_per = CW'(vecs[i].mn);
            max_per = CW'(vecs[i].mx);
            repeat (6 * (vecs[i].hi + vecs[i].lo) + 40) @(posedge clk);
            pulse_clr();
            repeat (2 * (vecs[i].hi + vecs[i].lo) + 8) @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), valid, 1);
            chk($sformatf("v%0d_period", i), period, vecs[i].exp_per);
            chk($sformatf("v%0d_high", i), high_time, vecs[i].exp_ht);
            chk($sformatf("v%0d_fast", i), too_fast, vecs[i].exp_fast);
            chk($sformatf("v%0d_slow", i), too_slow, vecs[i].exp_slow);
            chk($sformatf("v%0d_lost", i), lost, 0);
        end

        // Clock stops low: the rise reaches the detector 3 edges after the pin,
        // so lost appears on the 44th edge after the pin rise (41 after detection).
        gen_hi  = 16;
        gen_lo  = 16;
        min_per = CW'(24);
        max_per = CW'(40);
        repeat (6 * 32 + 40) @(posedge clk);
        pulse_clr();
        @(posedge cnvclk);
        gen_lo = 3000;
        repeat (43) @(posedge clk);
        #1;
        chk("lost_early", lost, 0);
        chk("valid_before_lost", valid, 1);
        @(posedge clk);
        #1;
        chk("lost_set", lost, 1);
        chk("valid_after_lost", valid, 0);
        chk("lost_period_kept", period, 32);
        chk("lost_high_kept", high_time, 16);
        chk("lost_no_slow", too_slow, 0);
        gen_lo = 16;
        wait_valid(300, "resume_valid");
        chk("resume_period", period, 32);

        // Frame sampled 11 edges after the edge that registered the rise.
        repeat (64) @(posedge clk);
        @(posedge cnvclk);
        repeat (13) @(posedge clk);
        #1 frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        chk("frame_upd_set", frame_upd, 1);
        chk("frame_phase_11", frame_phase, 11);
        @(posedge clk);
        #1;
        chk("frame_upd_single", frame_upd, 0);

        // Frame on the same edge that registers a rise.
        @(posedge cnvclk);
        repeat (2) @(posedge clk);
        #1 frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        chk("frame_coinc_upd", frame_upd, 1);
        chk("frame_coinc_phase", frame_phase, 0);

        // cnvext drop keeps sticky flags and ignores frame.
        min_per = CW'(40);
        repeat (100) @(posedge clk);
        #1;
        chk("drop_pre_fast", too_fast, 1);
        cnvext = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drop_valid", valid, 0);
        chk("drop_fast_kept", too_fast, 1);
        chk("drop_period_kept", period, 32);
        frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        chk("drop_frame_ignored", frame_upd, 0);
        cnvext  = 1'b1;
        min_per = CW'(24);
        wait_valid(300, "reext_valid");

        // Async reset mid-cycle clears outputs without waiting for an edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
